adbg_jsp_apb_uart16550: RTL and testbench

- PCLK-domain core of the next-generation JTAG Serial Port.
- Presents a 16550-compatible APB target to the host.
- Depth-parametrised RX FIFO (JTAG→host) and TX FIFO (host→JTAG).
- Adds behaviour the first-generation port lacks: functional FCR trigger levels, overrun detection, character timeout, MCR loopback and PSLVERR on illegal FIFO accesses.
- JTAG-side strobes arrive already synchronised into PCLK (synchronisers live in the JSP wrapper).

---
 rtl/adbg_jsp_16550_pkg.sv | 66 ++++++
 rtl/adbg_jsp_apb_uart16550_if.sv | 27 ++
 rtl/adbg_jsp_sync_fifo.sv | 84 ++++++++
 rtl/adbg_jsp_apb_uart16550.sv | 235 +++++++++++++++++++++++
 tb/tb_adbg_jsp_apb_uart16550.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adbg_jsp_16550_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adbg_jsp_16550_pkg
//  Purpose  : Shared constants, types and helpers for the JSP 16550 APB core:
//             register indices, IIR codes, FCR layout and RX trigger levels.
//  Revision : 1.0  initial release
// ============================================================================
package adbg_jsp_16550_pkg;

    // Register indices (PADDR)
    localparam logic [2:0] REG_RBR_THR = 3'd0;
    localparam logic [2:0] REG_IER     = 3'd1;
    localparam logic [2:0] REG_IIR_FCR = 3'd2;
    localparam logic [2:0] REG_LCR     = 3'd3;
    localparam logic [2:0] REG_MCR     = 3'd4;
    localparam logic [2:0] REG_LSR     = 3'd5;
    localparam logic [2:0] REG_MSR     = 3'd6;
    localparam logic [2:0] REG_SCR     = 3'd7;

    // IIR codes, highest priority first
    localparam logic [7:0] IIR_RLS  = 8'hC6;
    localparam logic [7:0] IIR_RDA  = 8'hC4;
    localparam logic [7:0] IIR_CTO  = 8'hCC;
    localparam logic [7:0] IIR_THRE = 8'hC2;
    localparam logic [7:0] IIR_NONE = 8'hC1;

    // Modem status is fixed: CTS/DSR/DCD asserted
    localparam logic [7:0] MSR_VALUE = 8'hB0;

    // RX trigger level selection held in FCR[7:6]
    typedef enum logic [1:0] {
        TRIG_ONE       = 2'b00,
        TRIG_QUARTER   = 2'b01,
        TRIG_HALF      = 2'b10,
        TRIG_NEAR_FULL = 2'b11
    } trig_e;

    // FCR write layout
    typedef struct packed {
        trig_e      trig;
        logic [2:0] rsvd;
        logic       tx_clr;
        logic       rx_clr;
        logic       fifo_en;
    } fcr_struct;

    // Interrupt identification: first matching source wins
    function automatic logic [7:0] iir_code(
        input logic       oe,
        input logic [2:0] ier,
        input logic       rx_trig,
        input logic       timeout,
        input logic       thre_arm,
        input logic       temt
    );
        logic [7:0] code;
        if (oe & ier[2])                   code = IIR_RLS;
        else if (rx_trig & ier[0])         code = IIR_RDA;
        else if (timeout & ier[0])         code = IIR_CTO;
        else if (thre_arm & temt & ier[1]) code = IIR_THRE;
        else                               code = IIR_NONE;
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adbg_jsp_apb_uart16550_if.sv
`default_nettype none
// ============================================================================
//  Module   : adbg_jsp_apb_uart16550_if
//  Purpose  : APB3 bus bundle (3-bit index, 8-bit data) for the JSP 16550.
//  Revision : 1.0  initial release
// ============================================================================
interface adbg_jsp_apb_uart16550_if;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [2:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface
`default_nettype wire

// File: rtl/adbg_jsp_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : adbg_jsp_sync_fifo
//  Purpose  : Single-clock FIFO with synchronous clear. A push into a full
//             FIFO is accepted only when a pop happens in the same cycle;
//             clear overrides both push and pop.
//  Revision : 1.0  initial release
// ============================================================================
module adbg_jsp_sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  wire logic             PCLK,
    input  wire logic             rst_i,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic             clr,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic      [CW-1:0]    count,
    output logic                  full,
    output logic                  empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Next-state of storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                // When full with a pop, wr_ptr equals rd_ptr: the head is
                // replaced only after it has been read out this cycle.
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge PCLK or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adbg_jsp_apb_uart16550.sv
`default_nettype none
// ============================================================================
//  Module   : adbg_jsp_apb_uart16550
//  Purpose  : PCLK-domain core of the JTAG Serial Port. 16550-style APB
//             register file over an RX FIFO (JTAG->host) and a TX FIFO
//             (host->JTAG), with trigger levels, overrun, character timeout,
//             loopback and PSLVERR on illegal FIFO accesses.
//  Revision : 1.0  initial release
// ============================================================================
module adbg_jsp_apb_uart16550
    import adbg_jsp_16550_pkg::*;
#(
    parameter  int DEPTH   = 16,
    parameter  int TIMEOUT = 1024,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  wire logic                 PCLK,
    input  wire logic                 rst_i,
    input  wire logic                 jsp_wr_i,
    input  wire logic [7:0]           jsp_wdata_i,
    input  wire logic                 jsp_rd_i,
    output logic      [7:0]           jsp_rdata_o,
    output logic      [CW-1:0]        jsp_tx_avail_o,
    output logic      [CW-1:0]        jsp_rx_free_o,
    adbg_jsp_apb_uart16550_if.slave   apb,
    output logic                      int_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    // Registers
    logic [3:0]    ier_q, ier_d;
    logic [7:0]    lcr_q, lcr_d;
    logic [4:0]    mcr_q, mcr_d;
    logic [7:0]    scr_q, scr_d;
    logic [7:0]    dll_q, dll_d;
    logic [7:0]    dlm_q, dlm_d;
    trig_e         trig_q, trig_d;
    logic          oe_q, oe_d;
    logic          arm_q, arm_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          int_q, int_d;

    // FIFO interface
    logic [7:0]    rx_dout, tx_dout, rx_din;
    logic [CW-1:0] rx_count, tx_count, rx_count_nxt, tx_count_nxt;
    logic          rx_full, rx_empty, tx_full, tx_empty;
    logic          rx_push_ok, rx_pop_ok, tx_push_ok, tx_pop_ok;
    logic          rx_clr, tx_clr;

    // Access decode
    logic          acc, wr_acc, rd_acc, dlab, loop;
    logic          thr_wr, rbr_rd, ier_wr, fcr_wr, iir_rd, lsr_rd, lb_wr;
    logic          tx_push_req, rx_push_req, oe_set, arm_set, arm_clr;
    fcr_struct     fcr;
    logic [7:0]    iir_now, lsr, rdata;
    logic          unused_fcr_bits;

    function automatic logic [CW-1:0] trig_level(input trig_e t);
        logic [CW-1:0] lvl;
        case (t)
            TRIG_ONE:     lvl = CW'(1);
            TRIG_QUARTER: lvl = CW'(DEPTH / 4);
            TRIG_HALF:    lvl = CW'(DEPTH / 2);
            default:      lvl = CW'(DEPTH - 2);
        endcase
        return lvl;
    endfunction

    assign acc    = apb.PSEL & apb.PENABLE;
    assign wr_acc = acc & apb.PWRITE;
    assign rd_acc = acc & ~apb.PWRITE;
    assign dlab   = lcr_q[7];
    assign loop   = mcr_q[4];
    assign fcr    = fcr_struct'(apb.PWDATA);
    assign unused_fcr_bits = ^{fcr.rsvd, fcr.fifo_en};

    assign thr_wr = wr_acc & (apb.PADDR == REG_RBR_THR) & ~dlab;
    assign rbr_rd = rd_acc & (apb.PADDR == REG_RBR_THR) & ~dlab;
    assign ier_wr = wr_acc & (apb.PADDR == REG_IER) & ~dlab;
    assign fcr_wr = wr_acc & (apb.PADDR == REG_IIR_FCR);
    assign iir_rd = rd_acc & (apb.PADDR == REG_IIR_FCR);
    assign lsr_rd = rd_acc & (apb.PADDR == REG_LSR);

    // FIFO control: a clear beats any push or pop to the same FIFO
    assign rx_clr      = fcr_wr & fcr.rx_clr;
    assign tx_clr      = fcr_wr & fcr.tx_clr;
    assign lb_wr       = thr_wr & loop;
    assign tx_push_req = thr_wr & ~loop;
    // In loopback the THR byte owns the RX write port; a colliding JTAG byte
    // is dropped and reported as an overrun.
    assign rx_push_req = lb_wr | jsp_wr_i;
    assign rx_din      = lb_wr ? apb.PWDATA : jsp_wdata_i;
    assign rx_pop_ok   = rbr_rd & ~rx_empty & ~rx_clr;
    assign tx_pop_ok   = jsp_rd_i & ~tx_empty & ~tx_clr;
    assign rx_push_ok  = rx_push_req & (~rx_full | rx_pop_ok) & ~rx_clr;
    assign tx_push_ok  = tx_push_req & (~tx_full | tx_pop_ok) & ~tx_clr;

    assign rx_count_nxt = rx_clr ? '0 : rx_count + CW'(rx_push_ok) - CW'(rx_pop_ok);
    assign tx_count_nxt = tx_clr ? '0 : tx_count + CW'(tx_push_ok) - CW'(tx_pop_ok);

    assign oe_set  = jsp_wr_i & (lb_wr | (rx_full & ~rx_pop_ok));
    assign iir_now = iir_code(oe_q, ier_q[2:0], rx_count >= trig_level(trig_q),
                              tmo_q == TW'(TIMEOUT), arm_q, tx_empty);
    assign arm_set = (tx_pop_ok & ~tx_push_ok & (tx_count == CW'(1)))
                   | (ier_wr & apb.PWDATA[1] & tx_empty);
    assign arm_clr = thr_wr | (iir_rd & (iir_now == IIR_THRE));

    assign lsr = {1'b0, tx_empty, ~tx_full, 3'b000, oe_q, ~rx_empty};

    adbg_jsp_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
        .PCLK  (PCLK),
        .rst_i (rst_i),
        .push  (rx_push_ok),
        .pop   (rx_pop_ok),
        .clr   (rx_clr),
        .din   (rx_din),
        .dout  (rx_dout),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    adbg_jsp_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
        .PCLK  (PCLK),
        .rst_i (rst_i),
        .push  (tx_push_ok),
        .pop   (tx_pop_ok),
        .clr   (tx_clr),
        .din   (apb.PWDATA),
        .dout  (tx_dout),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // Register writes, flag updates, timeout and interrupt next-state
    always_comb begin
        ier_d  = ier_q;
        lcr_d  = lcr_q;
        mcr_d  = mcr_q;
        scr_d  = scr_q;
        dll_d  = dll_q;
        dlm_d  = dlm_q;
        trig_d = trig_q;
        if (wr_acc) begin
            case (apb.PADDR)
                REG_RBR_THR: if (dlab) dll_d = apb.PWDATA;
                REG_IER:     if (dlab) dlm_d = apb.PWDATA;
                             else      ier_d = apb.PWDATA[3:0];
                REG_IIR_FCR: trig_d = fcr.trig;
                REG_LCR:     lcr_d  = apb.PWDATA;
                REG_MCR:     mcr_d  = apb.PWDATA[4:0];
                REG_SCR:     scr_d  = apb.PWDATA;
                default:     ;
            endcase
        end

        // A new overrun in the same cycle as an LSR read stays visible
        if (oe_set)      oe_d = 1'b1;
        else if (lsr_rd) oe_d = 1'b0;
        else             oe_d = oe_q;

        if (arm_clr)      arm_d = 1'b0;
        else if (arm_set) arm_d = 1'b1;
        else              arm_d = arm_q;

        if (rx_push_ok | rx_pop_ok | rx_empty) tmo_d = '0;
        else if (tmo_q != TW'(TIMEOUT))        tmo_d = tmo_q + TW'(1);
        else                                   tmo_d = tmo_q;

        // Evaluated on next-state so int_o rises one cycle after its cause
        int_d = (iir_code(oe_d, ier_d[2:0], rx_count_nxt >= trig_level(trig_d),
                          tmo_d == TW'(TIMEOUT), arm_d, tx_count_nxt == '0)
                 != IIR_NONE);
    end

    // Read data mux, driven only during a read access
    always_comb begin
        rdata = 8'h00;
        if (rd_acc) begin
            case (apb.PADDR)
                REG_RBR_THR: rdata = dlab ? dll_q : (rx_empty ? 8'h00 : rx_dout);
                REG_IER:     rdata = dlab ? dlm_q : {4'h0, ier_q};
                REG_IIR_FCR: rdata = iir_now;
                REG_LCR:     rdata = lcr_q;
                REG_MCR:     rdata = {3'b000, mcr_q};
                REG_LSR:     rdata = lsr;
                REG_MSR:     rdata = MSR_VALUE;
                default:     rdata = scr_q;
            endcase
        end
    end

    // Control/status registers, cleared asynchronously
    always_ff @(posedge PCLK or posedge rst_i) begin
        if (rst_i) begin
            ier_q  <= '0;
            lcr_q  <= '0;
            mcr_q  <= '0;
            scr_q  <= '0;
            dll_q  <= '0;
            dlm_q  <= '0;
            trig_q <= TRIG_ONE;
            oe_q   <= 1'b0;
            arm_q  <= 1'b0;
            tmo_q  <= '0;
            int_q  <= 1'b0;
        end else begin
            ier_q  <= ier_d;
            lcr_q  <= lcr_d;
            mcr_q  <= mcr_d;
            scr_q  <= scr_d;
            dll_q  <= dll_d;
            dlm_q  <= dlm_d;
            trig_q <= trig_d;
            oe_q   <= oe_d;
            arm_q  <= arm_d;
            tmo_q  <= tmo_d;
            int_q  <= int_d;
        end
    end

    assign apb.PRDATA  = rdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = (lb_wr & ~rx_push_ok) | (tx_push_req & ~tx_push_ok)
                       | (rbr_rd & rx_empty);

    assign jsp_rdata_o    = tx_empty ? 8'h00 : tx_dout;
    assign jsp_tx_avail_o = tx_count;
    assign jsp_rx_free_o  = CW'(DEPTH) - rx_count;
    assign int_o          = int_q;

endmodule
`default_nettype wire

// File: tb/tb_adbg_jsp_apb_uart16550.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adbg_jsp_apb_uart16550
//  Purpose  : Self-checking bench: queue-based behavioural model checked
//             every cycle, directed scenarios with literal expectations, and
//             a randomized APB/JTAG traffic phase.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adbg_jsp_apb_uart16550;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 1024;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic          PCLK = 1'b0;
    logic          rst_i = 1'b1;
    logic          jsp_wr_i = 1'b0;
    logic [7:0]    jsp_wdata_i = 8'h00;
    logic          jsp_rd_i = 1'b0;
    logic [7:0]    jsp_rdata_o;
    logic [CW-1:0] jsp_tx_avail_o;
    logic [CW-1:0] jsp_rx_free_o;
    logic          int_o;

    adbg_jsp_apb_uart16550_if apb();

    adbg_jsp_apb_uart16550 #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .PCLK           (PCLK),
        .rst_i          (rst_i),
        .jsp_wr_i       (jsp_wr_i),
        .jsp_wdata_i    (jsp_wdata_i),
        .jsp_rd_i       (jsp_rd_i),
        .jsp_rdata_o    (jsp_rdata_o),
        .jsp_tx_avail_o (jsp_tx_avail_o),
        .jsp_rx_free_o  (jsp_rx_free_o),
        .apb            (apb.slave),
        .int_o          (int_o)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [3:0] m_ier;
    logic [7:0] m_lcr, m_scr, m_dll, m_dlm;
    logic [4:0] m_mcr;
    int         m_trig;
    bit         m_oe, m_arm;
    int         m_tmo;

    task automatic model_reset();
        rxq.delete(); txq.delete();
        m_ier = 0; m_lcr = 0; m_scr = 0; m_dll = 0; m_dlm = 0; m_mcr = 0;
        m_trig = 1; m_oe = 0; m_arm = 0; m_tmo = 0;
    endtask

    function automatic logic [7:0] model_iir();
        if (m_oe && m_ier[2])                            return 8'hC6;
        if (rxq.size() >= m_trig && m_ier[0])            return 8'hC4;
        if (m_tmo == TIMEOUT && m_ier[0])                return 8'hCC;
        if (m_arm && txq.size() == 0 && m_ier[1])        return 8'hC2;
        return 8'hC1;
    endfunction

    task automatic model_step();
        logic [7:0] iir, exp_rd, lsr, d, rx_byte;
        logic [2:0] a;
        bit acc, wr, rd, dlab, lb, thr, rbr, fcr, exp_err;
        bit rx_clr, tx_clr, rx_pop, tx_pop, rx_push, tx_push, oe_set, arm_set, arm_clr, rx_was_empty;
        int nrx, ntx;

        nrx  = rxq.size();
        ntx  = txq.size();
        acc  = apb.PSEL && apb.PENABLE;
        wr   = acc && apb.PWRITE;
        rd   = acc && !apb.PWRITE;
        a    = apb.PADDR;
        d    = apb.PWDATA;
        dlab = m_lcr[7];
        lb   = m_mcr[4];
        thr  = wr && a == 3'd0 && !dlab;
        rbr  = rd && a == 3'd0 && !dlab;
        fcr  = wr && a == 3'd2;
        iir  = model_iir();
        lsr  = {1'b0, (ntx == 0), (ntx < DEPTH), 3'b000, m_oe, (nrx > 0)};

        // outputs
        chk("int_o", int_o, (iir != 8'hC1));
        chk("jsp_rdata", jsp_rdata_o, ntx > 0 ? txq[0] : 8'h00);
        chk("tx_avail", jsp_tx_avail_o, ntx);
        chk("rx_free", jsp_rx_free_o, DEPTH - nrx);
        chk("pready", apb.PREADY, 1);
        exp_err = (thr && lb && nrx == DEPTH)
               || (thr && !lb && ntx == DEPTH && !(jsp_rd_i && ntx > 0))
               || (rbr && nrx == 0);
        chk("pslverr", apb.PSLVERR, exp_err);
        if (rd) begin
            case (a)
                3'd0:    exp_rd = dlab ? m_dll : (nrx > 0 ? rxq[0] : 8'h00);
                3'd1:    exp_rd = dlab ? m_dlm : {4'h0, m_ier};
                3'd2:    exp_rd = iir;
                3'd3:    exp_rd = m_lcr;
                3'd4:    exp_rd = {3'b000, m_mcr};
                3'd5:    exp_rd = lsr;
                3'd6:    exp_rd = 8'hB0;
                default: exp_rd = m_scr;
            endcase
            chk("prdata", apb.PRDATA, exp_rd);
        end

        // state update for the coming edge
        rx_clr       = fcr && d[1];
        tx_clr       = fcr && d[2];
        rx_was_empty = (nrx == 0);
        rx_pop       = rbr && nrx > 0;
        tx_pop       = jsp_rd_i && ntx > 0 && !tx_clr;
        oe_set       = jsp_wr_i && ((thr && lb) || (nrx == DEPTH && !rx_pop));
        rx_push      = 0;
        rx_byte      = 8'h00;
        if (thr && lb) begin
            rx_push = nrx < DEPTH;
            rx_byte = d;
        end else if (jsp_wr_i) begin
            rx_push = nrx < DEPTH || rx_pop;
            rx_byte = jsp_wdata_i;
        end
        if (rx_clr) rx_push = 0;
        tx_push = thr && !lb && (ntx < DEPTH || tx_pop);
        arm_set = (tx_pop && ntx == 1 && !tx_push)
               || (wr && a == 3'd1 && !dlab && d[1] && ntx == 0);
        arm_clr = thr || (rd && a == 3'd2 && iir == 8'hC2);

        if (rx_clr) rxq.delete();
        else begin
            if (rx_pop)  void'(rxq.pop_front());
            if (rx_push) rxq.push_back(rx_byte);
        end
        if (tx_clr) txq.delete();
        else begin
            if (tx_pop)  void'(txq.pop_front());
            if (tx_push) txq.push_back(d);
        end

        if (rx_push || rx_pop || rx_was_empty) m_tmo = 0;
        else if (m_tmo < TIMEOUT)              m_tmo++;

        if (oe_set)                      m_oe = 1;
        else if (rd && a == 3'd5)        m_oe = 0;
        if (arm_clr)                     m_arm = 0;
        else if (arm_set)                m_arm = 1;

        if (wr) begin
            case (a)
                3'd0: if (dlab) m_dll = d;
                3'd1: if (dlab) m_dlm = d; else m_ier = d[3:0];
                3'd2: case (d[7:6])
                          2'b00:   m_trig = 1;
                          2'b01:   m_trig = DEPTH / 4;
                          2'b10:   m_trig = DEPTH / 2;
                          default: m_trig = DEPTH - 2;
                      endcase
                3'd3: m_lcr = d;
                3'd4: m_mcr = d[4:0];
                3'd7: m_scr = d;
                default: ;
            endcase
        end
    endtask

    // Compare process: DUT against the model on every falling edge
    always @(negedge PCLK) begin
        if (rst_i) begin
            model_reset();
            chk("rst_int", int_o, 0);
            chk("rst_tx_avail", jsp_tx_avail_o, 0);
            chk("rst_rx_free", jsp_rx_free_o, DEPTH);
        end else begin
            model_step();
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] rdv;
    logic       erv;
    int         waited;
    int         ph;
    logic [7:0] rnd;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic apb_xfer(input bit wr, input logic [2:0] a, input logic [7:0] d,
                            output logic [7:0] rdata, output logic err);
        apb.PSEL = 1; apb.PENABLE = 0; apb.PWRITE = wr; apb.PADDR = a; apb.PWDATA = d;
        tick();
        apb.PENABLE = 1;
        @(negedge PCLK);
        rdata = apb.PRDATA;
        err   = apb.PSLVERR;
        tick();
        apb.PSEL = 0; apb.PENABLE = 0;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] r; logic e;
        apb_xfer(1'b1, a, d, r, e);
    endtask

    task automatic jsp_push(input logic [7:0] b);
        jsp_wr_i = 1; jsp_wdata_i = b;
        tick();
        jsp_wr_i = 0;
    endtask

    initial begin
        logic [7:0] exp_regs [8];
        exp_regs = '{8'h00, 8'h00, 8'hC1, 8'h00, 8'h00, 8'h60, 8'hB0, 8'h00};
        apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = 0; apb.PWDATA = 0;
        repeat (3) tick();
        rst_i = 0;
        tick();

        // Reset values of all registers
        for (int i = 0; i < 8; i++) begin
            apb_xfer(1'b0, 3'(i), 8'h00, rdv, erv);
            chk($sformatf("reset_reg%0d", i), rdv, exp_regs[i]);
        end
        chk("reset_int", int_o, 0);

        // Trigger level 8 with RDA interrupt
        wr_reg(3'd2, 8'h80);
        wr_reg(3'd1, 8'h01);
        for (int i = 0; i < 7; i++) jsp_push(8'(i + 1));
        chk("trig_7_int", int_o, 0);
        jsp_push(8'h08);
        chk("trig_8_int", int_o, 1);
        apb_xfer(1'b0, 3'd2, 8'h00, rdv, erv);
        chk("trig_iir", rdv, 8'hC4);
        apb_xfer(1'b0, 3'd0, 8'h00, rdv, erv);
        chk("trig_rbr", rdv, 8'h01);
        chk("trig_after_rd_int", int_o, 0);
        wr_reg(3'd2, 8'h02);
        chk("rx_cleared", jsp_rx_free_o, DEPTH);

        // Overrun
        wr_reg(3'd1, 8'h04);
        for (int i = 0; i < 17; i++) jsp_push(8'(8'h20 + i));
        chk("ovr_free", jsp_rx_free_o, 0);
        apb_xfer(1'b0, 3'd2, 8'h00, rdv, erv);
        chk("ovr_iir", rdv, 8'hC6);
        apb_xfer(1'b0, 3'd5, 8'h00, rdv, erv);
        chk("ovr_lsr", rdv, 8'h63);
        apb_xfer(1'b0, 3'd5, 8'h00, rdv, erv);
        chk("ovr_lsr2", rdv, 8'h61);
        apb_xfer(1'b0, 3'd0, 8'h00, rdv, erv);
        chk("ovr_head", rdv, 8'h20);
        wr_reg(3'd2, 8'h02);
        wr_reg(3'd1, 8'h00);

        // TX full
        for (int i = 0; i < 16; i++) wr_reg(3'd0, 8'(8'h40 + i));
        chk("tx_full_avail", jsp_tx_avail_o, 16);
        apb_xfer(1'b1, 3'd0, 8'hEE, rdv, erv);
        chk("tx_ovf_err", erv, 1);
        chk("tx_ovf_avail", jsp_tx_avail_o, 16);
        chk("tx_ovf_head", jsp_rdata_o, 8'h40);
        wr_reg(3'd2, 8'h04);

        // Loopback
        wr_reg(3'd4, 8'h10);
        wr_reg(3'd0, 8'h5A);
        apb_xfer(1'b0, 3'd5, 8'h00, rdv, erv);
        chk("lb_lsr", rdv, 8'h61);
        chk("lb_tx_avail", jsp_tx_avail_o, 0);
        apb_xfer(1'b0, 3'd0, 8'h00, rdv, erv);
        chk("lb_rbr", rdv, 8'h5A);
        chk("lb_rbr_err", erv, 0);
        apb_xfer(1'b0, 3'd0, 8'h00, rdv, erv);
        chk("lb_empty_rbr", rdv, 8'h00);
        chk("lb_empty_err", erv, 1);
        wr_reg(3'd4, 8'h00);

        // Character timeout
        wr_reg(3'd1, 8'h01);
        wr_reg(3'd2, 8'hC0);
        jsp_push(8'h77);
        for (waited = 0; waited < TIMEOUT + 20 && !int_o; waited++) tick();
        chk("tmo_int", int_o, 1);
        chk("tmo_cycles", waited, TIMEOUT);
        apb_xfer(1'b0, 3'd2, 8'h00, rdv, erv);
        chk("tmo_iir", rdv, 8'hCC);
        apb_xfer(1'b0, 3'd0, 8'h00, rdv, erv);
        chk("tmo_rbr", rdv, 8'h77);
        chk("tmo_cleared_int", int_o, 0);

        // Randomized traffic
        ph = 0;
        for (int c = 0; c < 3000; c++) begin
            jsp_wr_i    = ($urandom % 3) == 0;
            jsp_wdata_i = 8'($urandom);
            jsp_rd_i    = ($urandom % 4) == 0;
            case (ph)
                0: begin
                    if ($urandom % 2 == 1) begin
                        apb.PSEL = 1; apb.PENABLE = 0;
                        apb.PWRITE = 1'($urandom);
                        apb.PADDR  = 3'($urandom);
                        rnd = 8'($urandom);
                        if (apb.PADDR == 3'd2) begin
                            rnd[1] = ($urandom % 6) == 0;
                            rnd[2] = ($urandom % 6) == 0;
                        end
                        if (apb.PADDR == 3'd3) rnd[7] = ($urandom % 4) == 0;
                        if (apb.PADDR == 3'd4) rnd[4] = ($urandom % 3) == 0;
                        apb.PWDATA = rnd;
                        ph = 1;
                    end
                end
                1: begin
                    apb.PENABLE = 1;
                    ph = 2;
                end
                default: begin
                    apb.PSEL = 0; apb.PENABLE = 0;
                    ph = 0;
                end
            endcase
            tick();
        end
        jsp_wr_i = 0; jsp_rd_i = 0; apb.PSEL = 0; apb.PENABLE = 0;
        tick();

        // Asynchronous reset in the middle of activity
        wr_reg(3'd3, 8'h03);
        wr_reg(3'd4, 8'h00);
        wr_reg(3'd2, 8'h06);
        wr_reg(3'd1, 8'h01);
        wr_reg(3'd7, 8'h55);
        wr_reg(3'd0, 8'h11);
        jsp_push(8'h33);
        chk("pre_rst_int", int_o, 1);
        #2;
        rst_i = 1;
        #1;
        chk("async_rst_int", int_o, 0);
        chk("async_rst_tx", jsp_tx_avail_o, 0);
        chk("async_rst_rx", jsp_rx_free_o, DEPTH);
        tick();
        rst_i = 0;
        tick();
        apb_xfer(1'b0, 3'd3, 8'h00, rdv, erv);
        chk("post_rst_lcr", rdv, 8'h00);
        apb_xfer(1'b0, 3'd7, 8'h00, rdv, erv);
        chk("post_rst_scr", rdv, 8'h00);
        apb_xfer(1'b0, 3'd2, 8'h00, rdv, erv);
        chk("post_rst_iir", rdv, 8'hC1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
